// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   cnt_width : bit-counter width needed to index WIDTH operand bits
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Counter only has to reach WIDTH-1; guard keeps the width at least 1 bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell: computes a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits tie and a borrow arrives.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: {bout, diff} = a - b - bin, one bit per
// clock, LSB first, with valid/ready handshakes on both sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands
// SHIFT | processing one bit per cycle, WIDTH cycles total
// DONE  | out_valid=1, result held until out_ready
//
// Ports:
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      operands present on a, b, bin
//   in_ready  out 1      block can accept operands (IDLE)
//   a         in  WIDTH  minuend
//   b         in  WIDTH  subtrahend
//   bin       in  1      borrow in
//   out_valid out 1      diff/bout valid (DONE)
//   out_ready in  1      consumer accepts result
//   diff      out WIDTH  (a - b - bin) mod 2^WIDTH
//   bout      out 1      1 iff a < b + bin
//   busy      out 1      high in SHIFT or DONE
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             borrow_next;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= borrow_next;
          // Counter parks on the last index instead of wrapping.
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake/status flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign diff      = res_sr;
  assign bout      = borrow;

endmodule
